// File: rtl/if_stage_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
package if_stage_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

  typedef enum logic [1:0] {
    PCSRC_SEQ = 2'b00,
    PCSRC_BR  = 2'b01,
    PCSRC_JR  = 2'b10,
    PCSRC_J   = 2'b11
  } pcsrc_e;

  typedef enum logic [1:0] {
    S_REQ  = 2'b00,
    S_WAIT = 2'b01,
    S_HOLD = 2'b10
  } if_state_e;

  function automatic logic [31:0] redirect_target(input logic [1:0] sel,
                                                  input logic [31:0] bpc,
                                                  input logic [31:0] jpc,
                                                  input logic [31:0] jrpc);
    logic [31:0] t;
    t = jpc;
    case (pcsrc_e'(sel))
      PCSRC_BR: t = bpc;
      PCSRC_JR: t = jrpc;
      default:  t = jpc;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry {pc, inst} holding register used when decode is stalled and
// the SRAM has already returned the next instruction.
module if_skid_buf (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        unload,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_inst,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] inst
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      pc    <= 32'd0;
      inst  <= 32'd0;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= in_pc;
      inst  <= in_inst;
    end else if (unload) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, single-outstanding SRAM fetch FSM,
// IF/ID pipeline register with a skid buffer, and delay-slot aware redirect.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] jpc,
  input  logic [31:0] jrpc,
  input  logic        id_stall,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic [31:0] o_pc,
  output logic [31:0] o_inst,
  output logic        o_valid
);

  if_state_e   state;
  logic [31:0] fetch_pc;
  logic [31:0] req_pc;
  logic        pend_valid;
  logic [31:0] pend_target;

  logic        consume;
  logic        redirect;
  logic [31:0] target;
  logic [31:0] seq_next;
  logic        ifid_from_sram;
  logic        ifid_from_buf;
  logic        buf_load;
  logic        buf_valid;
  logic [31:0] buf_pc;
  logic [31:0] buf_inst;

  assign consume   = o_valid & ~id_stall;
  assign redirect  = consume & (pcsource != PCSRC_SEQ);
  assign target    = redirect_target(pcsource, bpc, jpc, jrpc);
  assign seq_next  = pend_valid ? pend_target : fetch_pc + 32'd4;

  assign ifid_from_sram = (state == S_WAIT) & inst_data_ok & (~o_valid | consume);
  assign buf_load       = (state == S_WAIT) & inst_data_ok & o_valid & ~consume;
  assign ifid_from_buf  = (state == S_HOLD) & buf_valid & consume;

  // Gated by reset so no request is presented while the SRAM port is held in reset.
  assign inst_req  = (state == S_REQ) & ~reset;
  assign inst_addr = fetch_pc;

  // A redirect seen before the delay slot is accepted is parked in pend_*,
  // otherwise it overwrites fetch_pc since the delay slot is already in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_REQ;
      fetch_pc    <= RESET_PC;
      req_pc      <= 32'd0;
      pend_valid  <= 1'b0;
      pend_target <= 32'd0;
    end else begin
      case (state)
        S_REQ: begin
          if (inst_addr_ok) begin
            req_pc     <= fetch_pc;
            fetch_pc   <= redirect ? target : seq_next;
            pend_valid <= 1'b0;
            state      <= S_WAIT;
          end else if (redirect) begin
            pend_valid  <= 1'b1;
            pend_target <= target;
          end
        end
        S_WAIT: begin
          if (redirect) fetch_pc <= target;
          if (inst_data_ok) state <= (~o_valid | consume) ? S_REQ : S_HOLD;
        end
        S_HOLD: begin
          if (redirect) fetch_pc <= target;
          if (consume) state <= S_REQ;
        end
        default: state <= S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_valid <= 1'b0;
      o_pc    <= 32'd0;
      o_inst  <= 32'd0;
    end else if (ifid_from_sram) begin
      o_valid <= 1'b1;
      o_pc    <= req_pc;
      o_inst  <= inst_rdata;
    end else if (ifid_from_buf) begin
      o_valid <= 1'b1;
      o_pc    <= buf_pc;
      o_inst  <= buf_inst;
    end else if (consume) begin
      o_valid <= 1'b0;
    end
  end

  if_skid_buf u_skid (
    .clk     (clk),
    .reset   (reset),
    .load    (buf_load),
    .unload  (ifid_from_buf),
    .in_pc   (req_pc),
    .in_inst (inst_rdata),
    .valid   (buf_valid),
    .pc      (buf_pc),
    .inst    (buf_inst)
  );

endmodule

// File: tb/tb_if_stage.sv
// Table-driven bench for if_stage: each row is one clock cycle of SRAM/decode
// inputs and the IF outputs expected during that cycle.
module tb_if_stage;

  localparam logic [31:0] R  = 32'hBFC0_0000;
  localparam logic [31:0] T  = 32'hBFC0_0100;
  localparam logic [31:0] JT = 32'hBFC0_0200;
  localparam logic [31:0] JR = 32'h8000_0000;

  localparam logic [31:0] I0  = 32'h2400_0000;
  localparam logic [31:0] I1  = 32'h2400_0004;
  localparam logic [31:0] BR  = 32'h1000_0010;
  localparam logic [31:0] DS  = 32'h2400_000C;
  localparam logic [31:0] T0  = 32'h2400_0100;
  localparam logic [31:0] JRI = 32'h03E0_0008;
  localparam logic [31:0] JDS = 32'h2400_0008;
  localparam logic [31:0] K0  = 32'h3C00_0000;

  typedef struct {
    logic        rst;
    logic        stall;
    logic [1:0]  psrc;
    logic        aok;
    logic        dok;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
  } row_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  pcsource = 2'b00;
  logic        id_stall = 1'b0;
  logic        inst_addr_ok = 1'b0;
  logic        inst_data_ok = 1'b0;
  logic [31:0] inst_rdata = 32'd0;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] o_pc;
  logic [31:0] o_inst;
  logic        o_valid;

  int   tests = 0;
  int   fails = 0;
  row_t rows[$];

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(R)) dut (
    .clk          (clk),
    .reset        (reset),
    .pcsource     (pcsource),
    .bpc          (T),
    .jpc          (JT),
    .jrpc         (JR),
    .id_stall     (id_stall),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .o_pc         (o_pc),
    .o_inst       (o_inst),
    .o_valid      (o_valid)
  );

  task automatic add_row(input logic rst, input logic st, input logic [1:0] ps,
                         input logic aok, input logic dok, input logic [31:0] rd,
                         input logic e_req, input logic [31:0] e_addr,
                         input logic e_valid, input logic [31:0] e_pc,
                         input logic [31:0] e_inst);
    row_t r;
    r.rst = rst;  r.stall = st;  r.psrc = ps;  r.aok = aok;  r.dok = dok;
    r.rdata = rd; r.e_req = e_req; r.e_addr = e_addr; r.e_valid = e_valid;
    r.e_pc = e_pc; r.e_inst = e_inst;
    rows.push_back(r);
  endtask

  task automatic check_output(input string name, input int idx,
                              input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL row%0d %s: got %h, expected %h", idx, name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    pcsource = 2'b00; id_stall = 1'b0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'd0;
  endtask

  // Leaves the bench 1 time unit after a rising edge with reset released.
  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic apply_stimulus(input row_t r);
    id_stall     = r.stall;
    pcsource     = r.psrc;
    inst_addr_ok = r.aok;
    inst_data_ok = r.dok;
    inst_rdata   = r.rdata;
  endtask

  task automatic run_row(input row_t r, input int idx);
    if (r.rst) do_reset();
    apply_stimulus(r);
    @(negedge clk);
    check_output("inst_req", idx, {31'd0, inst_req}, {31'd0, r.e_req});
    check_output("inst_addr", idx, inst_addr, r.e_addr);
    check_output("o_valid", idx, {31'd0, o_valid}, {31'd0, r.e_valid});
    if (r.e_valid) begin
      check_output("o_pc", idx, o_pc, r.e_pc);
      check_output("o_inst", idx, o_inst, r.e_inst);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Sequential fetch, then a taken branch whose delay slot is accepted in the same cycle.
    add_row(1,0,2'd0,1,0,0,       1,R,        0,0,0);
    add_row(0,0,2'd0,0,1,I0,      0,R+4,      0,0,0);
    add_row(0,0,2'd0,1,0,0,       1,R+4,      1,R,I0);
    add_row(0,0,2'd0,0,1,I1,      0,R+8,      0,0,0);
    add_row(0,0,2'd0,1,0,0,       1,R+8,      1,R+4,I1);
    add_row(0,0,2'd0,0,1,BR,      0,R+12,     0,0,0);
    add_row(0,0,2'd1,1,0,0,       1,R+12,     1,R+8,BR);
    add_row(0,0,2'd0,0,1,DS,      0,T,        0,0,0);
    add_row(0,0,2'd0,1,0,0,       1,T,        1,R+12,DS);
    add_row(0,0,2'd0,0,1,T0,      0,T+4,      0,0,0);
    add_row(0,0,2'd0,0,0,0,       1,T+4,      1,T,T0);
    add_row(0,0,2'd0,0,1,32'hDEADBEEF, 1,T+4, 0,0,0);
    add_row(0,0,2'd0,0,0,0,       1,T+4,      0,0,0);
    // Branch while the delay-slot request waits three cycles for addr_ok.
    add_row(1,0,2'd0,1,0,0,       1,R,        0,0,0);
    add_row(0,0,2'd0,0,1,I0,      0,R+4,      0,0,0);
    add_row(0,0,2'd0,1,0,0,       1,R+4,      1,R,I0);
    add_row(0,0,2'd0,0,1,I1,      0,R+8,      0,0,0);
    add_row(0,0,2'd0,1,0,0,       1,R+8,      1,R+4,I1);
    add_row(0,0,2'd0,0,1,BR,      0,R+12,     0,0,0);
    add_row(0,0,2'd1,0,0,0,       1,R+12,     1,R+8,BR);
    add_row(0,0,2'd0,0,0,0,       1,R+12,     0,0,0);
    add_row(0,0,2'd0,0,0,0,       1,R+12,     0,0,0);
    add_row(0,0,2'd0,1,0,0,       1,R+12,     0,0,0);
    add_row(0,0,2'd0,0,1,DS,      0,T,        0,0,0);
    add_row(0,0,2'd0,1,0,0,       1,T,        1,R+12,DS);
    add_row(0,0,2'd0,0,0,0,       0,T+4,      0,0,0);
    // Four-cycle stall with data returning into the skid buffer.
    add_row(1,0,2'd0,1,0,0,       1,R,        0,0,0);
    add_row(0,0,2'd0,0,1,I0,      0,R+4,      0,0,0);
    add_row(0,1,2'd0,1,0,0,       1,R+4,      1,R,I0);
    add_row(0,1,2'd0,0,1,I1,      0,R+8,      1,R,I0);
    add_row(0,1,2'd0,0,0,0,       0,R+8,      1,R,I0);
    add_row(0,1,2'd0,0,0,0,       0,R+8,      1,R,I0);
    add_row(0,0,2'd0,0,0,0,       0,R+8,      1,R,I0);
    add_row(0,0,2'd0,0,0,0,       1,R+8,      1,R+4,I1);
    add_row(0,0,2'd0,0,0,0,       1,R+8,      0,0,0);
    // jr resolved while its delay slot sits in the skid buffer, then a j via pend.
    add_row(1,0,2'd0,1,0,0,       1,R,        0,0,0);
    add_row(0,0,2'd0,0,1,I0,      0,R+4,      0,0,0);
    add_row(0,0,2'd0,1,0,0,       1,R+4,      1,R,I0);
    add_row(0,0,2'd0,0,1,JRI,     0,R+8,      0,0,0);
    add_row(0,1,2'd0,1,0,0,       1,R+8,      1,R+4,JRI);
    add_row(0,1,2'd0,0,1,JDS,     0,R+12,     1,R+4,JRI);
    add_row(0,0,2'd2,0,0,0,       0,R+12,     1,R+4,JRI);
    add_row(0,0,2'd0,1,0,0,       1,JR,       1,R+8,JDS);
    add_row(0,0,2'd0,0,1,K0,      0,JR+4,     0,0,0);
    add_row(0,0,2'd3,0,0,0,       1,JR+4,     1,JR,K0);
    add_row(0,0,2'd0,1,0,0,       1,JR+4,     0,0,0);
    add_row(0,0,2'd0,0,0,0,       0,JT,       0,0,0);

    for (int i = 0; i < rows.size(); i++) run_row(rows[i], i);

    // Asynchronous reset while a fetch is outstanding and IF/ID is live.
    rows.delete();
    add_row(1,0,2'd0,1,0,0,       1,R,        0,0,0);
    add_row(0,0,2'd0,0,1,I0,      0,R+4,      0,0,0);
    add_row(0,1,2'd0,1,0,0,       1,R+4,      1,R,I0);
    for (int i = 0; i < rows.size(); i++) run_row(rows[i], 100 + i);
    idle_inputs();
    #2 reset = 1'b1;
    #1;
    check_output("async inst_req", 200, {31'd0, inst_req}, 32'd0);
    check_output("async o_valid", 200, {31'd0, o_valid}, 32'd0);
    check_output("async o_pc", 200, o_pc, 32'd0);
    check_output("async o_inst", 200, o_inst, 32'd0);
    check_output("async inst_addr", 200, inst_addr, R);
    @(posedge clk);
    #1 reset = 1'b0;
    rows.delete();
    add_row(0,0,2'd0,1,0,0,       1,R,        0,0,0);
    add_row(0,0,2'd0,0,1,I0,      0,R+4,      0,0,0);
    add_row(0,0,2'd0,0,0,0,       1,R+4,      1,R,I0);
    for (int i = 0; i < rows.size(); i++) run_row(rows[i], 300 + i);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
